// File: rtl/ahb_native_mem_bridge.sv
// AHB-Lite slave bridging single transfers onto a PicoRV32-style native memory port.
// Byte lanes become mem_wstrb, mem_ready supplies wait states, and a hung target times out into ERROR.
module ahb_native_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic [3:0]       r_wstrb;
  logic             r_instr;
  logic             r_write;
  logic [31:0]      r_hrdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_can_sample;
  logic             w_accept;
  logic             w_legal;
  logic [3:0]       w_wstrb;
  logic             w_timeout;
  logic             w_unused_ok;

  assign w_unused_ok  = ^hprot[3:1];

  assign w_can_sample = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  assign w_accept     = w_can_sample && hsel && hready && htrans[1];
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Size/alignment decode; reads never assert strobes.
  always_comb begin
    w_legal = 1'b0;
    w_wstrb = 4'b0000;
    case (hsize)
      3'b000: begin
        w_legal = 1'b1;
        w_wstrb = 4'b0001 << haddr[1:0];
      end
      3'b001: begin
        w_legal = ~haddr[0];
        w_wstrb = haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        w_legal = (haddr[1:0] == 2'b00);
        w_wstrb = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
        w_wstrb = 4'b0000;
      end
    endcase
    if (!hwrite) begin
      w_wstrb = 4'b0000;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_accept) begin
          w_next = w_legal ? S_ACCESS : S_ERR1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        // A completion on the timeout edge still counts as a completion.
        if (mem_ready) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERR1;
        end
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wstrb  <= '0;
      r_instr  <= 1'b0;
      r_write  <= 1'b0;
      r_hrdata <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_legal) begin
        r_addr  <= {haddr[31:2], 2'b00};
        r_wstrb <= w_wstrb;
        r_instr <= ~hprot[0];
        r_write <= hwrite;
        r_cnt   <= '0;
      end else if ((r_state == S_ACCESS) && !mem_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_ACCESS) && mem_ready && !r_write) begin
        r_hrdata <= mem_rdata;
      end
    end
  end

  // Handshake outputs decode straight from the state register so reset clears them at once.
  assign mem_valid = (r_state == S_ACCESS);
  assign hreadyout = !((r_state == S_ACCESS) || (r_state == S_ERR1));
  assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata    = r_hrdata;
  assign mem_addr  = r_addr;
  assign mem_wstrb = r_wstrb;
  assign mem_instr = r_instr;
  assign mem_wdata = hwdata;

endmodule

// File: tb/tb_ahb_native_mem_bridge.sv
// Directed scoreboard bench for ahb_native_mem_bridge: a driver queues AHB and native
// expectations, a native target model and an AHB monitor pop and compare them.
module tb_ahb_native_mem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  assign hready = hreadyout;

  always #5 clk = ~clk;

  ahb_native_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        resp;
    bit          chk_rd;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic        instr;
    logic        wr;
    logic [31:0] wdata;
    int          lat;     // mem_valid cycle that gets mem_ready; 0 = never
    logic [31:0] rdata;
    int          cycles;  // expected mem_valid length; 0 = unchecked
    int          gap;     // expected idle cycles before request; -1 = unchecked
  } nat_t;

  ahb_exp_t    exp_q[$];
  nat_t        nat_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] r_next_wdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic ahb_exp_t mk_e(input logic resp, input bit chk_rd, input logic [31:0] rd);
    ahb_exp_t e;
    e.resp = resp; e.chk_rd = chk_rd; e.rdata = rd;
    return e;
  endfunction

  function automatic nat_t mk_n(input logic [31:0] a, input logic [3:0] s, input logic ins,
                                input logic wr, input logic [31:0] wd, input int lat,
                                input logic [31:0] rd, input int cyc, input int gap);
    nat_t n;
    n.addr = a; n.wstrb = s; n.instr = ins; n.wr = wr; n.wdata = wd;
    n.lat = lat; n.rdata = rd; n.cycles = cyc; n.gap = gap;
    return n;
  endfunction

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hreadyout) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got hreadyout=0 expected 1 within 200 cycles", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [3:0] prot, input logic [31:0] wd, input ahb_exp_t e,
                      input bit has_nat, input nat_t n);
    exp_q.push_back(e);
    if (has_nat) nat_q.push_back(n);
    hsel   = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    hprot  = prot;
    hwdata = r_next_wdata;
    wait_ready("addr_phase");
    r_next_wdata = wd;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = r_next_wdata;
    wait_ready("data_phase");
  endtask

  // Native target model: checks each request on its first cycle and answers after n.lat cycles.
  nat_t cur;
  bit   in_req;
  int   cyc;
  int   gap;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    in_req    = 1'b0;
    cyc       = 0;
    gap       = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_req    = 1'b0;
        mem_ready = 1'b0;
        gap       = 0;
      end else if (mem_valid) begin
        if (!in_req) begin
          in_req = 1'b1;
          cyc    = 1;
          if (nat_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_mem_valid: got mem_valid=1 addr %h expected no request", mem_addr);
            cur = mk_n(mem_addr, mem_wstrb, mem_instr, 1'b0, '0, 1, '0, 0, -1);
          end else begin
            cur = nat_q.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
            chk("mem_instr", {31'd0, mem_instr}, {31'd0, cur.instr});
            if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
            if (cur.gap >= 0) chk("mem_valid_gap", gap, cur.gap);
          end
        end else begin
          cyc++;
        end
        if ((cur.lat != 0) && (cyc == cur.lat)) begin
          mem_ready = 1'b1;
          mem_rdata = cur.rdata;
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        if (in_req) begin
          if (cur.cycles != 0) chk("mem_valid_cycles", cyc, cur.cycles);
          in_req = 1'b0;
          gap    = 0;
        end
        gap++;
        mem_ready = 1'b0;
      end
    end
  end

  // AHB monitor: pops an expectation whenever a data phase closes with hreadyout=1.
  bit pending;
  bit err_seen;
  int n_done;
  initial begin
    pending  = 1'b0;
    err_seen = 1'b0;
    n_done   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending  = 1'b0;
        err_seen = 1'b0;
      end else begin
        if (pending) begin
          if (!hreadyout) begin
            if (hresp) err_seen = 1'b1;
          end else begin
            ahb_exp_t e;
            n_done++;
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_completion#%0d: got completion expected none", n_done);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("resp_two_cycle#%0d", n_done), {30'd0, hresp, err_seen},
                  {30'd0, e.resp, e.resp});
              if (e.chk_rd) chk($sformatf("hrdata#%0d", n_done), hrdata, e.rdata);
            end
            pending  = 1'b0;
            err_seen = 1'b0;
          end
        end
        if (hsel && hready && htrans[1]) pending = 1'b1;
      end
    end
  end

  nat_t nn;
  initial begin
    nn = mk_n('0, '0, 1'b0, 1'b0, '0, 1, '0, 0, -1);
    reset = 1'b1;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b000;
    hprot = 4'b0001; hwdata = '0; r_next_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_instr", {31'd0, mem_instr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word read with 3-cycle target, then byte write on the top lane.
    xfer(32'h100, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b0, 1, 32'hDEADBEEF), 1,
         mk_n(32'h100, 4'b0000, 1'b0, 1'b0, '0, 3, 32'hDEADBEEF, 3, -1));
    idle_bus();
    xfer(32'h203, 1'b1, 3'b000, 4'b0001, 32'hAB000000, mk_e(1'b0, 1, 32'hDEADBEEF), 1,
         mk_n(32'h200, 4'b1000, 1'b0, 1'b1, 32'hAB000000, 1, '0, 1, -1));
    idle_bus();

    // Illegal sizes/alignments back-to-back, last one followed by a legal accept from ERR2.
    xfer(32'h301, 1'b0, 3'b001, 4'b0001, '0, mk_e(1'b1, 0, '0), 0, nn);
    xfer(32'h302, 1'b1, 3'b010, 4'b0001, 32'h55555555, mk_e(1'b1, 0, '0), 0, nn);
    xfer(32'h000, 1'b0, 3'b011, 4'b0001, '0, mk_e(1'b1, 0, '0), 0, nn);
    xfer(32'h006, 1'b1, 3'b001, 4'b0001, 32'h12340000, mk_e(1'b0, 1, 32'hDEADBEEF), 1,
         mk_n(32'h004, 4'b1100, 1'b0, 1'b1, 32'h12340000, 2, '0, 2, -1));
    xfer(32'h001, 1'b1, 3'b000, 4'b0001, 32'h0000CD00, mk_e(1'b0, 0, '0), 1,
         mk_n(32'h000, 4'b0010, 1'b0, 1'b1, 32'h0000CD00, 1, '0, 1, -1));
    idle_bus();

    // Opcode fetch (hprot[0]=0) half read, then word write keeping hrdata.
    xfer(32'h302, 1'b0, 3'b001, 4'b0000, '0, mk_e(1'b0, 1, 32'h5A5A1234), 1,
         mk_n(32'h300, 4'b0000, 1'b1, 1'b0, '0, 2, 32'h5A5A1234, 2, -1));
    xfer(32'h010, 1'b1, 3'b010, 4'b0001, 32'hCAFEF00D, mk_e(1'b0, 1, 32'h5A5A1234), 1,
         mk_n(32'h010, 4'b1111, 1'b0, 1'b1, 32'hCAFEF00D, 1, '0, 1, -1));
    idle_bus();

    // BUSY with hsel, NONSEQ without hsel: no wait states, no native access.
    hsel = 1'b1; haddr = 32'h100; htrans = 2'b01; hwrite = 1'b0; hsize = 3'b010;
    @(negedge clk);
    chk("busy_hreadyout", {31'd0, hreadyout}, 32'd1);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b10;
    @(negedge clk);
    chk("unsel_hreadyout", {31'd0, hreadyout}, 32'd1);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    chk("no_access_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("no_access_hreadyout", {31'd0, hreadyout}, 32'd1);
    @(posedge clk); #1;

    // Timeout: never-ready target, then ready on the last allowed cycle.
    xfer(32'h080, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b1, 0, '0), 1,
         mk_n(32'h080, 4'b0000, 1'b0, 1'b0, '0, 0, '0, TO, -1));
    idle_bus();
    xfer(32'h084, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b0, 1, 32'h0BADC0DE), 1,
         mk_n(32'h084, 4'b0000, 1'b0, 1'b0, '0, TO, 32'h0BADC0DE, TO, -1));
    idle_bus();

    // Pipelined reads against a zero-wait target.
    xfer(32'h000, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b0, 1, 32'h11111111), 1,
         mk_n(32'h000, 4'b0000, 1'b0, 1'b0, '0, 1, 32'h11111111, 1, -1));
    xfer(32'h004, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b0, 1, 32'h22222222), 1,
         mk_n(32'h004, 4'b0000, 1'b0, 1'b0, '0, 1, 32'h22222222, 1, 1));
    idle_bus();

    // Reset during ACCESS abandons the transfer immediately.
    xfer(32'h040, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b0, 0, '0), 1,
         mk_n(32'h040, 4'b0000, 1'b0, 1'b0, '0, 0, '0, 0, -1));
    hsel = 1'b0; htrans = 2'b00; hwdata = r_next_wdata;
    @(posedge clk); #3;
    chk("pre_reset_mem_valid", {31'd0, mem_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("async_rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("async_rst_hresp", {31'd0, hresp}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    nat_q.delete();
    chk("post_rst_hrdata", hrdata, 32'd0);
    xfer(32'h100, 1'b0, 3'b010, 4'b0001, '0, mk_e(1'b0, 1, 32'h77665544), 1,
         mk_n(32'h100, 4'b0000, 1'b0, 1'b0, '0, 2, 32'h77665544, 2, -1));
    idle_bus();

    for (int i = 0; i < 50; i++) begin
      if ((exp_q.size() == 0) && (nat_q.size() == 0)) break;
      @(negedge clk);
    end
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("nat_q_drained", 32'(nat_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
